// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans an external 8:1 bit mux and assembles its eight bits
// into one word. Before each bit is sampled, the select is held stable for
// SETTLE_CYC cycles (legal range 1..15). Completed words go to a one-deep
// output slot with a valid/ready handshake. If a word completes while the
// slot is still full, that word is dropped and overrun pulses for one cycle.
//
// Optional feature (macro MUX_SCAN_CHANGE_DET_EN): adds the output
// 'changed', which is the XOR of each newly loaded frame with the
// previously loaded frame.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a single frame scan (only looked at in IDLE)
//   cont         continuous scanning while high
//   mux_y        bit returned by the external mux (synchronous to clk)
//   mux_sel      select driven to the external mux
//   busy         high whenever a scan is in progress
//   frame        last loaded word
//   frame_valid  frame holds a word not yet consumed
//   frame_ready  consumer accept
//   overrun      one-cycle pulse when a completed word is dropped
//   changed      (MUX_SCAN_CHANGE_DET_EN only) frame XOR previous frame
//
// state  | meaning
// IDLE   | no scan in progress
// SETTLE | select held stable while the mux output settles
// SAMPLE | one cycle; mux_y is captured into bit mux_sel
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_y,
  output logic [2:0] mux_sel,
  output logic       busy,
  output logic [7:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       overrun
`ifdef MUX_SCAN_CHANGE_DET_EN
  ,
  output logic [7:0] changed
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] asm_q, asm_d;
  logic       word_done;
  logic       slot_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= 4'd0;
      asm_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || cont) begin
          state_d = SETTLE;
          sel_d   = 3'd0;
          cnt_d   = 4'd0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        asm_d[sel_q] = mux_y;
        cnt_d        = 4'd0;
        if (sel_q == 3'd7) begin
          // asm_d already holds bit 7, so the slot gets the complete word
          word_done = 1'b1;
          sel_d     = 3'd0;
          state_d   = cont ? SETTLE : IDLE;
        end else begin
          sel_d   = sel_q + 3'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full slot that is being consumed in the same cycle may still load.
  assign slot_load = word_done && (!frame_valid || frame_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame       <= 8'd0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= word_done && frame_valid && !frame_ready;
      if (slot_load) begin
        frame       <= asm_d;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_SCAN_CHANGE_DET_EN
  // frame only changes on a load, so it already holds the previously loaded word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 8'd0;
    else if (slot_load) changed <= asm_d ^ frame;
  end
`endif

  assign mux_sel = sel_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, is the number of cycles the select is held stable before each sample; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  single-shot request to scan one frame; sampled only in IDLE.
REQ-005 cont  input  1  continuous mode; while high, a new scan begins immediately after each frame.
REQ-006 mux_y  input  1  output of the downstream 8:1 bit mux, treated as synchronous to clk.
REQ-007 mux_sel  output  3  select driven to the 8:1 bit mux.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 frame  output  8  assembled word; bit i equals mux_y sampled while mux_sel == i.
REQ-010 frame_valid  output  1  frame holds a word not yet consumed.
REQ-011 frame_ready  input  1  consumer accepts frame when frame_valid and frame_ready are both high at a rising edge.
REQ-012 overrun  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-013 FSM states: IDLE, SETTLE, SAMPLE.
REQ-014 IDLE -> SETTLE when (start or cont) = 1; at this transition mux_sel = 0 and the settle counter = 0.
REQ-015 SETTLE: counter increments each cycle; mux_sel is held; after SETTLE_CYC cycles in SETTLE, go to SAMPLE.
REQ-016 SAMPLE (one cycle): capture mux_y into bit mux_sel of the shift/assembly register.
REQ-017 SAMPLE with mux_sel < 7: mux_sel increments, counter clears, go to SETTLE.
REQ-018 SAMPLE with mux_sel = 7: the completed word, including the bit captured this cycle, is offered to the output slot; mux_sel wraps to 0.
REQ-019 After a SAMPLE with mux_sel = 7, go to SETTLE if cont = 1, else go to IDLE.
REQ-020 Each channel takes SETTLE_CYC+1 cycles; frame_valid rises 8*(SETTLE_CYC+1) cycles after the edge that leaves IDLE.
REQ-021 Output slot load: the word loads if frame_valid = 0, or if frame_valid = 1 and frame_ready = 1 in the same cycle (simultaneous consume and load); frame_valid then stays 1.
REQ-022 Output slot full (frame_valid = 1, frame_ready = 0) at completion: the new word is discarded, frame is unchanged, and overrun pulses high for exactly one cycle.
REQ-023 While frame_valid = 1, frame does not change except on a load per REQ-021.
REQ-024 frame_valid clears on an accept edge that has no simultaneous load.
REQ-025 start asserted while busy is ignored; cont deasserted mid-frame lets the current frame finish, then goes to IDLE.
REQ-026 mux_sel changes only on the SAMPLE -> SETTLE or SAMPLE -> IDLE edge, never inside SETTLE.

Reset
REQ-027 On rst_n low, immediately (asynchronously): state = IDLE, mux_sel = 0, counter = 0, assembly register = 0, frame = 0, frame_valid = 0, overrun = 0, busy = 0.
REQ-028 Reset mid-scan abandons the partial word; no frame_valid is produced for it after reset release.

Configuration
REQ-029 Macro MUX_SCAN_CHANGE_DET_EN: when defined, add output changed [7:0] = frame XOR previously loaded frame, updated on each load; both are 0 after reset, so the first frame compares against 0.
REQ-030 MUX_SCAN_CHANGE_DET_EN undefined: the changed port and its history register are absent; all other behaviour is identical.

Verification
REQ-031 SETTLE_CYC=2; mux inputs d=8'hA5, mux_y=d[mux_sel]; start pulse; frame_ready=1 -> frame_valid high 24 cycles after leaving IDLE with frame=8'hA5; busy then low.
REQ-032 cont=1, frame_ready=0, d=8'h3C -> first frame=8'h3C held; second completion produces an overrun pulse and frame stays 8'h3C.
REQ-033 cont=1, frame_ready=1 only in the completion cycle of frame 2 (d changed 8'h0F -> 8'hF0) -> frame=8'hF0, frame_valid stays 1, no overrun.
REQ-034 rst_n low while mux_sel=4, then released -> all outputs 0, mux_sel=0, state IDLE; no frame_valid until a new start.
REQ-035 start held high during a scan -> exactly one frame, then IDLE; mux_sel steps 0..7, each value held for 3 cycles.
REQ-036 With MUX_SCAN_CHANGE_DET_EN, frames 8'h55 then 8'h57 -> changed=8'h55 then 8'h02.
